// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the IF stage: registered 1-cycle fetch with
// stall/flush/fault handling, plus a streaming program-load port.
module instr_mem_loadable #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0000,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  // Fetch port
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  // Load port: a word transfers on every rising edge where load_valid and
  // load_ready are both high; load_ready is high for the whole LOAD state and
  // never depends on load_valid, so the source may hold or drop valid freely.
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy,
  // Debug view of the load FSM (0 = RUN, 1 = LOAD)
  output logic [0:0]        dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mem_we;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_bad;
  logic              load_hold;

  // ---------------------------------------------------------------------------
  // Load FSM and write index
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        // A restart wins over a word offered in the same cycle.
        if (load_start) begin
          idx_d = '0;
        end else if (load_valid) begin
          mem_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (load_last || (idx_q == IDX_W'(DEPTH - 1))) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch register
  // ---------------------------------------------------------------------------
  assign fetch_idx = pc[IDX_W+1:2];
  assign fetch_bad = (|pc[1:0]) | (|pc[ADDR_W-1:IDX_W+2]);

  // Covers both "already loading" and "entering LOAD this edge".
  assign load_hold = (state_q == ST_LOAD) | load_start;

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (load_hold) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      valid_d = valid_q;
      fault_d = fault_q;
    end else if (fetch_en && fetch_bad) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b1;
    end else if (fetch_en) begin
      instr_d = mem_q[fetch_idx];
      valid_d = 1'b1;
      fault_d = 1'b0;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign load_ready  = (state_q == ST_LOAD);
  assign load_busy   = (state_q == ST_LOAD);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed scenarios plus a randomized fetch
// stream checked against an array model of the program store.
module tb_instr_mem_loadable;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] instr;
  logic        instr_valid, fault;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready, load_busy;
  logic [0:0]  dbg_state;

  instr_mem_loadable #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .fetch_en(fetch_en), .stall(stall),
    .flush(flush), .instr(instr), .instr_valid(instr_valid), .fault(fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] exp_instr;
  logic        exp_valid, exp_fault;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_en = 0; stall = 0; flush = 0;
    load_start = 0; load_valid = 0; load_last = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick();
    vec_cnt++;
    if (instr !== NOP || instr_valid !== 1'b0 || fault !== 1'b0 ||
        load_ready !== 1'b0 || load_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_hold: got instr=%h v=%b f=%b rdy=%b busy=%b want %h/0/0/0/0",
               instr, instr_valid, fault, load_ready, load_busy, NOP);
    end
    reset_n = 1;
    tick(); tick();
    vec_cnt++;
    if (instr !== NOP || instr_valid !== 1'b0 || fault !== 1'b0 || load_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: got instr=%h v=%b f=%b busy=%b want %h/0/0/0",
               instr, instr_valid, fault, load_busy, NOP);
    end
  endtask

  task automatic test_load_basic();
    logic [31:0] words [3];
    logic [31:0] got;
    words[0] = 32'h2004_0005; words[1] = 32'h0000_1026; words[2] = 32'h0C00_0004;
    load_start = 1;
    tick();
    load_start = 0;
    vec_cnt++;
    if (load_busy !== 1'b1 || load_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL load_enter: got busy=%b rdy=%b want 1/1", load_busy, load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = words[i]; load_last = (i == 2);
      model_mem[i] = words[i];
      exp_q.push_back(words[i]);
      tick();
    end
    // A word offered outside LOAD must not land anywhere.
    load_data = 32'hDEAD_BEEF; load_last = 0;
    vec_cnt++;
    if (load_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_last_exit: got busy=%b want 0", load_busy);
    end
    tick();
    load_valid = 0;
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1; pc = 32'(i * 4);
      tick();
      got = exp_q.pop_front();
      vec_cnt++;
      if (instr !== got || instr_valid !== 1'b1 || fault !== 1'b0) begin
        err_cnt++;
        $display("FAIL load_fetch[%0d]: got %h v=%b f=%b want %h v=1 f=0",
                 i, instr, instr_valid, fault, got);
      end
    end
    fetch_en = 0;
    tick();
    vec_cnt++;
    if (instr !== words[2] || instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_hold: got %h v=%b want %h v=0", instr, instr_valid, words[2]);
    end
  endtask

  task automatic test_fault();
    fetch_en = 1; pc = 32'(4 * DEPTH);
    tick();
    vec_cnt++;
    if (instr !== NOP || instr_valid !== 1'b0 || fault !== 1'b1) begin
      err_cnt++;
      $display("FAIL fault_range: got %h v=%b f=%b want %h v=0 f=1", instr, instr_valid, fault, NOP);
    end
    pc = 32'h2;
    tick();
    vec_cnt++;
    if (fault !== 1'b1 || instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL fault_align: got v=%b f=%b want v=0 f=1", instr_valid, fault);
    end
    pc = 32'h0;
    tick();
    vec_cnt++;
    if (fault !== 1'b0 || instr_valid !== 1'b1 || instr !== model_mem[0]) begin
      err_cnt++;
      $display("FAIL fault_clear: got %h v=%b f=%b want %h v=1 f=0",
               instr, instr_valid, fault, model_mem[0]);
    end
    fetch_en = 0;
  endtask

  task automatic test_stall_flush();
    fetch_en = 1; pc = 32'h0;
    tick();
    stall = 1; pc = 32'h4;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (instr !== model_mem[0] || instr_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL stall_hold[%0d]: got %h v=%b want %h v=1", i, instr, instr_valid, model_mem[0]);
      end
    end
    stall = 0;
    tick();
    vec_cnt++;
    if (instr !== model_mem[1] || instr_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_resume: got %h v=%b want %h v=1", instr, instr_valid, model_mem[1]);
    end
    stall = 1; flush = 1;
    tick();
    vec_cnt++;
    if (instr !== NOP || instr_valid !== 1'b0 || fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_flush: got %h v=%b f=%b want %h v=0 f=0", instr, instr_valid, fault, NOP);
    end
    idle_inputs();
  endtask

  task automatic test_full_load();
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1; load_data = $urandom;
      model_mem[i] = load_data;
      tick();
      if (i == DEPTH - 2) begin
        vec_cnt++;
        if (load_busy !== 1'b1) begin
          err_cnt++;
          $display("FAIL full_load_busy: got busy=%b want 1", load_busy);
        end
      end
    end
    load_valid = 0;
    vec_cnt++;
    if (load_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_load_exit: got busy=%b want 0", load_busy);
    end
    fetch_en = 1; pc = 32'(4 * (DEPTH - 1));
    tick();
    vec_cnt++;
    if (instr !== model_mem[DEPTH-1] || instr_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_load_last: got %h v=%b want %h v=1", instr, instr_valid, model_mem[DEPTH-1]);
    end
    fetch_en = 0;
    tick();
    exp_instr = model_mem[DEPTH-1]; exp_valid = 0; exp_fault = 0;
  endtask

  task automatic test_fetch_random();
    logic bad;
    for (int n = 0; n < 300; n++) begin
      stall    = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 8);
      fetch_en = ($urandom_range(0, 99) < 75);
      case ($urandom_range(0, 9))
        0:       pc = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1:       pc = 32'($urandom_range(1, 4000)) << 10;
        default: pc = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      bad = (pc % 4 != 0) || (pc >= 32'(4 * DEPTH));
      if (flush) begin
        exp_instr = NOP; exp_valid = 0; exp_fault = 0;
      end else if (stall) begin
        // IF/ID register frozen
      end else if (fetch_en && bad) begin
        exp_instr = NOP; exp_valid = 0; exp_fault = 1;
      end else if (fetch_en) begin
        exp_instr = model_mem[pc / 4]; exp_valid = 1; exp_fault = 0;
      end else begin
        exp_valid = 0;
      end
      tick();
      vec_cnt++;
      if (instr !== exp_instr || instr_valid !== exp_valid || fault !== exp_fault) begin
        err_cnt++;
        $display("FAIL rand_fetch[%0d] pc=%h: got %h v=%b f=%b want %h v=%b f=%b",
                 n, pc, instr, instr_valid, fault, exp_instr, exp_valid, exp_fault);
      end
    end
    idle_inputs();
  endtask

  task automatic test_restart();
    logic [31:0] wa, wb, wc, wd;
    wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
    fetch_en = 1; pc = 32'h0; load_start = 1;
    tick();
    load_start = 0;
    vec_cnt++;
    if (instr !== NOP || instr_valid !== 1'b0 || load_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL restart_enter: got %h v=%b busy=%b want %h v=0 busy=1", instr, instr_valid, load_busy, NOP);
    end
    load_valid = 1; load_data = wa; tick();
    load_data = wb; tick();
    load_start = 1; load_data = wc; tick();
    load_start = 0; load_data = wd; load_last = 1; tick();
    load_valid = 0; load_last = 0;
    model_mem[0] = wd; model_mem[1] = wb;
    vec_cnt++;
    if (load_busy !== 1'b0 || instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL restart_exit: got busy=%b v=%b want busy=0 v=0", load_busy, instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      tick();
      vec_cnt++;
      if (instr !== model_mem[i] || instr_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL restart_fetch[%0d]: got %h v=%b want %h v=1", i, instr, instr_valid, model_mem[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_load();
    load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = $urandom;
      model_mem[i] = load_data;
      tick();
    end
    load_data = $urandom;
    #2 reset_n = 0;
    #1;
    vec_cnt++;
    if (load_busy !== 1'b0 || instr !== NOP || instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_load: got busy=%b %h v=%b want busy=0 %h v=0", load_busy, instr, instr_valid, NOP);
    end
    load_valid = 0;
    tick();
    reset_n = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1; pc = 32'(i * 4);
      tick();
      vec_cnt++;
      if (instr !== model_mem[i] || instr_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL reset_load_fetch[%0d]: got %h v=%b want %h v=1", i, instr, instr_valid, model_mem[i]);
      end
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_load_basic();
    test_fault();
    test_stall_flush();
    test_full_load();
    test_fetch_random();
    test_restart();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
